cdb_arbiter: RTL and testbench

//  Shares the single common data bus (CDB) between two result producers: the ALU and the load/store buffer.

---
 rtl/cdb_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Shares one common data bus between the ALU and the load/store
//            buffer. Each source owns a small FIFO with a same-cycle bypass.
//            A round-robin grant broadcasts at most one {rob_id, value} per
//            cycle to the reservation stations, ROB and register file.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int DEPTH  = 4,   // entries per source FIFO, power of two, >= 2
  parameter int ROB_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              _clear,
  input  logic              _alu_res_ready,
  input  logic [ROB_W-1:0]  _alu_res_rob_id,
  input  logic [DATA_W-1:0] _alu_res_value,
  input  logic              _lsb_res_ready,
  input  logic [ROB_W-1:0]  _lsb_res_rob_id,
  input  logic [DATA_W-1:0] _lsb_res_value,
  output logic              _alu_full,
  output logic              _lsb_full,
  output logic              _cdb_ready,
  output logic [ROB_W-1:0]  _cdb_rob_id,
  output logic [DATA_W-1:0] _cdb_value,
  output logic              _cdb_src,
  output logic              _overflow
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_ent_w = ROB_W + DATA_W;

  localparam logic [c_cnt_w-1:0] c_cnt_depth  = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_almost = c_cnt_w'(DEPTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one    = c_ptr_w'(1);

  // Source encoding, also the value driven on _cdb_src; index 0 = ALU, 1 = LSB.
  localparam logic c_src_alu = 1'b0;
  localparam logic c_src_lsb = 1'b1;

  // A cycle does useful work only when globally ready and not flushing.
  logic                    w_active;
  logic [1:0]              w_push;
  logic [1:0][c_ent_w-1:0] w_push_ent;
  logic [1:0]              w_cand_vld;
  logic [1:0][c_ent_w-1:0] w_cand_ent;
  logic [1:0]              w_ovf_evt;
  logic [1:0]              w_full;
  logic                    w_contend;
  logic                    w_pick_lsb;
  logic                    w_gnt_any;
  logic [1:0]              w_gnt;

  // Round-robin history: r_rr_last is the source that won the last
  // contention; r_rr_seen stays low until the first contention after
  // reset/flush so that contention is resolved in favour of the ALU.
  logic                    r_rr_last;
  logic                    r_rr_seen;

  assign w_active      = rdy_in & ~_clear;
  assign w_push        = {_lsb_res_ready, _alu_res_ready} & {2{w_active}};
  assign w_push_ent[0] = {_alu_res_rob_id, _alu_res_value};
  assign w_push_ent[1] = {_lsb_res_rob_id, _lsb_res_value};

  // --------------------------------------------------------------------------
  // Per-source FIFO with bypass. The candidate is the FIFO head when the FIFO
  // holds anything, otherwise the incoming push, which keeps per-source order
  // strict while giving single-cycle latency through an empty FIFO.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic [c_ent_w-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_has_head;
    logic               w_at_cap;
    logic               w_bypass_used;
    logic               w_write;
    logic               w_pop;

    assign w_has_head     = (r_count != '0);
    assign w_at_cap       = (r_count == c_cnt_depth);
    assign w_cand_vld[gi] = w_has_head | w_push[gi];
    assign w_cand_ent[gi] = w_has_head ? r_mem[r_rd_ptr] : w_push_ent[gi];

    // A grant with an empty FIFO consumes the bypassed push directly.
    assign w_pop          = w_gnt[gi] & w_has_head;
    assign w_bypass_used  = w_gnt[gi] & ~w_has_head;
    assign w_write        = w_push[gi] & ~w_bypass_used & ~w_at_cap;
    assign w_ovf_evt[gi]  = w_push[gi] & w_at_cap;

    // One slot of slack absorbs the push already in the producer's pipe.
    assign w_full[gi]     = (r_count >= c_cnt_almost);

    // Payload storage; entries are qualified by r_count so no reset needed.
    always_ff @(posedge clk_in) begin
      if (w_write) begin
        r_mem[r_wr_ptr] <= w_push_ent[gi];
      end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else if (_clear) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else if (rdy_in) begin
        if (w_write) begin
          r_wr_ptr <= r_wr_ptr + c_ptr_one;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
        case ({w_write, w_pop})
          2'b10:   r_count <= r_count + c_cnt_one;
          2'b01:   r_count <= r_count - c_cnt_one;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign _alu_full = w_full[0];
  assign _lsb_full = w_full[1];

  // --------------------------------------------------------------------------
  // Grant: a lone candidate always wins; on contention the source that did
  // not win the previous contention goes, with the ALU first after a reset
  // or flush.
  // --------------------------------------------------------------------------
  assign w_contend  = w_cand_vld[0] & w_cand_vld[1];
  assign w_pick_lsb = w_contend ? (r_rr_seen & (r_rr_last == c_src_alu))
                                : w_cand_vld[1];
  assign w_gnt_any  = w_active & (|w_cand_vld);
  assign w_gnt      = {w_gnt_any & w_pick_lsb, w_gnt_any & ~w_pick_lsb};

  // Round-robin history update on every contended grant.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rr_last <= c_src_alu;
      r_rr_seen <= 1'b0;
    end else if (_clear) begin
      r_rr_last <= c_src_alu;
      r_rr_seen <= 1'b0;
    end else if (rdy_in && w_contend) begin
      r_rr_last <= w_pick_lsb ? c_src_lsb : c_src_alu;
      r_rr_seen <= 1'b1;
    end
  end

  // Registered broadcast; payload fields hold when nothing is granted.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      _cdb_ready  <= 1'b0;
      _cdb_rob_id <= '0;
      _cdb_value  <= '0;
      _cdb_src    <= c_src_alu;
    end else if (_clear) begin
      _cdb_ready  <= 1'b0;
    end else if (rdy_in) begin
      _cdb_ready <= w_gnt_any;
      if (w_gnt_any) begin
        {_cdb_rob_id, _cdb_value} <= w_pick_lsb ? w_cand_ent[1] : w_cand_ent[0];
        _cdb_src                  <= w_pick_lsb ? c_src_lsb : c_src_alu;
      end
    end
  end

  // Sticky overflow flag; a flush leaves it set, only reset clears it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      _overflow <= 1'b0;
    end else if (w_active && (|w_ovf_evt)) begin
      _overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Directed self-checking bench for cdb_arbiter (DEPTH = 4).
//            ALU values are 0xA0000000 + rob, LSB values 0xB0000000 + rob.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int DEPTH  = 4;
  localparam int ROB_W  = 5;
  localparam int DATA_W = 32;

  logic              clk_in    = 1'b0;
  logic              rst_n_in  = 1'b1;
  logic              rdy_in    = 1'b1;
  logic              clear     = 1'b0;
  logic              alu_ready = 1'b0;
  logic [ROB_W-1:0]  alu_rob   = '0;
  logic [DATA_W-1:0] alu_val   = '0;
  logic              lsb_ready = 1'b0;
  logic [ROB_W-1:0]  lsb_rob   = '0;
  logic [DATA_W-1:0] lsb_val   = '0;
  logic              alu_full;
  logic              lsb_full;
  logic              cdb_ready;
  logic [ROB_W-1:0]  cdb_rob;
  logic [DATA_W-1:0] cdb_val;
  logic              cdb_src;
  logic              overflow;

  int n_tests = 0;
  int n_fail  = 0;

  cdb_arbiter #(.DEPTH(DEPTH), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .rdy_in          (rdy_in),
    ._clear          (clear),
    ._alu_res_ready  (alu_ready),
    ._alu_res_rob_id (alu_rob),
    ._alu_res_value  (alu_val),
    ._lsb_res_ready  (lsb_ready),
    ._lsb_res_rob_id (lsb_rob),
    ._lsb_res_value  (lsb_val),
    ._alu_full       (alu_full),
    ._lsb_full       (lsb_full),
    ._cdb_ready      (cdb_ready),
    ._cdb_rob_id     (cdb_rob),
    ._cdb_value      (cdb_val),
    ._cdb_src        (cdb_src),
    ._overflow       (overflow)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DATA_W-1:0] aval(input int r);
    return 32'hA000_0000 + 32'(r);
  endfunction

  function automatic logic [DATA_W-1:0] lval(input int r);
    return 32'hB000_0000 + 32'(r);
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of pushes, clock it, then check the broadcast.
  task automatic cyc(input string tag, input logic av, input int ar,
                     input logic lv, input int lr,
                     input logic erdy, input logic esrc, input int erob);
    alu_ready = av;
    alu_rob   = ROB_W'(ar);
    alu_val   = aval(ar);
    lsb_ready = lv;
    lsb_rob   = ROB_W'(lr);
    lsb_val   = lval(lr);
    tick();
    chk({tag, ".rdy"}, 64'(cdb_ready), 64'(erdy));
    if (erdy) begin
      chk({tag, ".src"}, 64'(cdb_src), 64'(esrc));
      chk({tag, ".rob"}, 64'(cdb_rob), 64'(erob));
      chk({tag, ".val"}, 64'(cdb_val), 64'(esrc ? lval(erob) : aval(erob)));
    end
  endtask

  task automatic do_clear(input string tag);
    alu_ready = 1'b0;
    lsb_ready = 1'b0;
    clear     = 1'b1;
    tick();
    clear     = 1'b0;
    chk({tag, ".rdy"}, 64'(cdb_ready), 64'd0);
  endtask

  initial begin
    // ---- reset state
    #1 rst_n_in = 1'b0;
    tick();
    chk("rst.rdy",  64'(cdb_ready), 64'd0);
    chk("rst.rob",  64'(cdb_rob),   64'd0);
    chk("rst.val",  64'(cdb_val),   64'd0);
    chk("rst.src",  64'(cdb_src),   64'd0);
    chk("rst.ovf",  64'(overflow),  64'd0);
    chk("rst.afull", 64'(alu_full), 64'd0);
    chk("rst.lfull", 64'(lsb_full), 64'd0);
    tick();
    rst_n_in = 1'b1;

    // ---- 1: single ALU push, one-cycle latency, then idle
    alu_ready = 1'b1;
    alu_rob   = 5'd3;
    alu_val   = 32'h11;
    tick();
    chk("t1.rdy", 64'(cdb_ready), 64'd1);
    chk("t1.rob", 64'(cdb_rob),   64'd3);
    chk("t1.val", 64'(cdb_val),   64'h11);
    chk("t1.src", 64'(cdb_src),   64'd0);
    alu_ready = 1'b0;
    tick();
    chk("t1.idle", 64'(cdb_ready), 64'd0);
    chk("t1.hold_rob", 64'(cdb_rob), 64'd3);
    chk("t1.hold_val", 64'(cdb_val), 64'h11);

    // ---- 2: both push every cycle, strict alternation, almost-full flags
    cyc("t2.k0", 1, 1, 1,  9, 1, 0, 1);
    cyc("t2.k1", 1, 2, 1, 10, 1, 1, 9);
    cyc("t2.k2", 1, 3, 1, 11, 1, 0, 2);
    cyc("t2.k3", 1, 4, 1, 12, 1, 1, 10);
    chk("t2.k3.lfull", 64'(lsb_full), 64'd0);
    chk("t2.k3.afull", 64'(alu_full), 64'd0);
    cyc("t2.k4", 1, 5, 1, 13, 1, 0, 3);
    chk("t2.k4.lfull", 64'(lsb_full), 64'd1);
    chk("t2.k4.afull", 64'(alu_full), 64'd0);
    cyc("t2.k5", 1, 6, 1, 14, 1, 1, 11);
    chk("t2.k5.afull", 64'(alu_full), 64'd1);
    cyc("t2.k6", 0, 0, 0, 0, 1, 0, 4);
    cyc("t2.k7", 0, 0, 0, 0, 1, 1, 12);
    cyc("t2.k8", 0, 0, 0, 0, 1, 0, 5);
    cyc("t2.k9", 0, 0, 0, 0, 1, 1, 13);
    cyc("t2.k10", 0, 0, 0, 0, 1, 0, 6);
    cyc("t2.k11", 0, 0, 0, 0, 1, 1, 14);
    cyc("t2.k12", 0, 0, 0, 0, 0, 0, 0);
    chk("t2.ovf", 64'(overflow), 64'd0);

    // ---- 3: fill LSB FIFO to DEPTH, push once more -> dropped, sticky overflow
    do_clear("t3.clr");
    cyc("t3.n0", 1, 1, 1, 1, 1, 0, 1);
    cyc("t3.n1", 1, 2, 1, 2, 1, 1, 1);
    cyc("t3.n2", 1, 3, 1, 3, 1, 0, 2);
    cyc("t3.n3", 1, 4, 1, 4, 1, 1, 2);
    cyc("t3.n4", 1, 5, 1, 5, 1, 0, 3);
    cyc("t3.n5", 1, 6, 1, 6, 1, 1, 3);
    cyc("t3.n6", 0, 0, 1, 7, 1, 0, 4);
    chk("t3.n6.lfull", 64'(lsb_full), 64'd1);
    chk("t3.n6.ovf",   64'(overflow), 64'd0);
    cyc("t3.n7", 0, 0, 1, 8, 1, 1, 4);
    chk("t3.n7.ovf",   64'(overflow), 64'd1);
    cyc("t3.n8", 0, 0, 0, 0, 1, 0, 5);
    cyc("t3.n9", 0, 0, 0, 0, 1, 1, 5);
    cyc("t3.n10", 0, 0, 0, 0, 1, 0, 6);
    cyc("t3.n11", 0, 0, 0, 0, 1, 1, 6);
    cyc("t3.n12", 0, 0, 0, 0, 1, 1, 7);
    cyc("t3.n13", 0, 0, 0, 0, 0, 0, 0);
    chk("t3.ovf_sticky", 64'(overflow), 64'd1);

    // ---- 4: flush with both FIFOs holding two entries
    do_clear("t4.pre");
    cyc("t4.c0", 1, 1, 1, 1, 1, 0, 1);
    cyc("t4.c1", 1, 2, 1, 2, 1, 1, 1);
    cyc("t4.c2", 1, 3, 1, 3, 1, 0, 2);
    cyc("t4.c3", 1, 4, 1, 4, 1, 1, 2);
    alu_ready = 1'b1;
    alu_rob   = 5'd9;
    alu_val   = aval(9);
    lsb_ready = 1'b1;
    lsb_rob   = 5'd9;
    lsb_val   = lval(9);
    clear     = 1'b1;
    tick();
    clear     = 1'b0;
    chk("t4.clr.rdy",   64'(cdb_ready), 64'd0);
    chk("t4.clr.afull", 64'(alu_full),  64'd0);
    chk("t4.clr.lfull", 64'(lsb_full),  64'd0);
    chk("t4.clr.ovf",   64'(overflow),  64'd1);
    cyc("t4.p0", 1, 10, 1, 10, 1, 0, 10);
    cyc("t4.p1", 0, 0, 0, 0, 1, 1, 10);
    cyc("t4.p2", 0, 0, 0, 0, 0, 0, 0);

    // ---- 5: rdy_in low for three cycles with both FIFOs non-empty
    do_clear("t5.pre");
    cyc("t5.p0", 1, 1, 1, 1, 1, 0, 1);
    cyc("t5.p1", 1, 2, 1, 2, 1, 1, 1);
    rdy_in = 1'b0;
    cyc("t5.h0", 1, 7, 1, 7, 1, 1, 1);
    cyc("t5.h1", 1, 7, 1, 7, 1, 1, 1);
    cyc("t5.h2", 1, 7, 1, 7, 1, 1, 1);
    chk("t5.h.afull", 64'(alu_full), 64'd0);
    chk("t5.h.lfull", 64'(lsb_full), 64'd0);
    rdy_in = 1'b1;
    cyc("t5.q0", 0, 0, 0, 0, 1, 0, 2);
    cyc("t5.q1", 0, 0, 0, 0, 1, 1, 2);
    cyc("t5.q2", 0, 0, 0, 0, 0, 0, 0);
    chk("t5.ovf", 64'(overflow), 64'd1);

    // ---- 6: asynchronous reset mid-cycle during traffic
    alu_ready = 1'b1;
    alu_rob   = 5'd1;
    alu_val   = aval(1);
    lsb_ready = 1'b1;
    lsb_rob   = 5'd1;
    lsb_val   = lval(1);
    tick();
    alu_rob   = 5'd2;
    alu_val   = aval(2);
    lsb_rob   = 5'd2;
    lsb_val   = lval(2);
    tick();
    chk("t6.busy", 64'(cdb_ready), 64'd1);
    #2 rst_n_in = 1'b0;
    #1;
    chk("t6.async.rdy", 64'(cdb_ready), 64'd0);
    chk("t6.async.rob", 64'(cdb_rob),   64'd0);
    chk("t6.async.val", 64'(cdb_val),   64'd0);
    chk("t6.async.src", 64'(cdb_src),   64'd0);
    chk("t6.async.ovf", 64'(overflow),  64'd0);
    alu_ready = 1'b0;
    lsb_ready = 1'b0;
    tick();
    rst_n_in = 1'b1;
    cyc("t6.empty", 0, 0, 0, 0, 0, 0, 0);
    chk("t6.ovf", 64'(overflow), 64'd0);
    cyc("t6.push", 1, 5, 0, 0, 1, 0, 5);
    cyc("t6.idle", 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
